// File: rtl/aes_mix_arbiter.sv
module aes_mix_arbiter #(
    parameter int DONE_GUARD = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [127:0] data0,
    input  logic         req1,
    input  logic [127:0] data1,
    output logic [1:0]   gnt,
    output logic [1:0]   rsp_valid,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic         busy,
    output logic         mc_start,
    output logic [127:0] mc_state,
    input  logic         mc_done,
    input  logic [127:0] mc_result
);

    localparam int GW = (DONE_GUARD > 1) ? $clog2(DONE_GUARD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_GUARD,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state, state_nx;
    logic            last;
    logic            win;
    logic            any_req;
    logic [GW-1:0]   guard_cnt;
    logic            guard_done;

`ifdef AES_MIXARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0]   wait_cnt;
    logic            timeout_q;
    logic            err_q;
`endif

    assign any_req    = req0 | req1;
    assign win        = (req0 && req1) ? ~last : req1;
    assign guard_done = (guard_cnt == GW'(DONE_GUARD - 1));

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        gnt      = 2'b00;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nx = S_LAUNCH;
                    if (reset) gnt = win ? 2'b10 : 2'b01;
                end
            end
            S_LAUNCH: state_nx = S_GUARD;
            S_GUARD:  if (guard_done) state_nx = S_WAIT;
            S_WAIT: begin
                if (mc_done) state_nx = S_RESP;
`ifdef AES_MIXARB_TIMEOUT_EN
                else if (timeout_q) state_nx = S_RESP;
`endif
            end
            S_RESP:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign mc_start  = (state == S_LAUNCH);
    assign rsp_valid = (state == S_RESP) ? (last ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mc_state  <= '0;
            rsp_data  <= '0;
            last      <= 1'b1;
            guard_cnt <= '0;
`ifdef AES_MIXARB_TIMEOUT_EN
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        mc_state <= win ? data1 : data0;
                        last     <= win;
`ifdef AES_MIXARB_TIMEOUT_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                S_LAUNCH: guard_cnt <= '0;
                S_GUARD: begin
                    guard_cnt <= guard_cnt + GW'(1);
`ifdef AES_MIXARB_TIMEOUT_EN
                    if (guard_done) begin
                        wait_cnt  <= '0;
                        timeout_q <= 1'b0;
                    end
`endif
                end
                S_WAIT: begin
                    if (mc_done) begin
                        rsp_data <= mc_result;
                    end
`ifdef AES_MIXARB_TIMEOUT_EN
                    else if (timeout_q) begin
                        rsp_data <= '0;
                        err_q    <= 1'b1;
                    end else begin
                        wait_cnt  <= wait_cnt + TW'(1);
                        timeout_q <= (wait_cnt == TW'(TIMEOUT_CYCLES));
                    end
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef AES_MIXARB_TIMEOUT_EN
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_mix_arbiter.sv
module tb_aes_mix_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [127:0] data0 = '0, data1 = '0;
    logic [1:0]   gnt, rsp_valid;
    logic [127:0] rsp_data, mc_state;
    logic         rsp_err, busy, mc_start;
    logic         mc_done = 1'b0;
    logic [127:0] mc_result = '0;

    always #5 clk = ~clk;

    aes_mix_arbiter #(.DONE_GUARD(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .mc_start(mc_start), .mc_state(mc_state),
        .mc_done(mc_done), .mc_result(mc_result)
    );

    logic [31:0] cin  [6] = '{32'h455313db, 32'h5c220af2, 32'h01010101,
                              32'hc6c6c6c6, 32'hd5d4d4d4, 32'h4c31262d};
    logic [31:0] cout [6] = '{32'hbca14d8e, 32'h9d58dc9f, 32'h01010101,
                              32'hc6c6c6c6, 32'hd6d7d5d5, 32'hf8bd7e4d};

    function automatic logic [127:0] pk_in(input int a, input int b, input int c, input int d);
        return {cin[d], cin[c], cin[b], cin[a]};
    endfunction
    function automatic logic [127:0] pk_out(input int a, input int b, input int c, input int d);
        return {cout[d], cout[c], cout[b], cout[a]};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3;
        b0 = c[7:0]; b1 = c[15:8]; b2 = c[23:16]; b3 = c[31:24];
        return {xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3),
                b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3,
                b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3,
                xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3};
    endfunction

    int           eng_mode = 0;
    int           ecnt = 0;
    logic [127:0] elatch = '0;

    always @(posedge clk) begin
        if (mc_start) begin
            elatch <= mc_state;
            if (eng_mode == 0)      begin mc_done <= 1'b0; ecnt <= 6; end
            else if (eng_mode == 1) ecnt <= 3;
            else                    begin mc_done <= 1'b0; ecnt <= 0; end
        end else if (ecnt == 1) begin
            ecnt      <= 0;
            mc_done   <= 1'b1;
            mc_result <= {mixcol(elatch[127:96]), mixcol(elatch[95:64]),
                          mixcol(elatch[63:32]), mixcol(elatch[31:0])};
        end else if (ecnt > 1) begin
            ecnt <= ecnt - 1;
        end
    end

    typedef struct {
        logic [1:0]   who;
        logic [127:0] data;
        logic         err;
        int           lat;
    } rsp_t;

    logic [1:0] gnt_q [$];
    rsp_t       rsp_q [$];
    int total = 0, bad = 0;
    int cyc = 0, gnt_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (reset) begin
            if (gnt != 2'b00) begin
                gnt_cyc = cyc;
                if (gnt_q.size() == 0) chk("gnt_unexpected", 128'(gnt), 128'(0));
                else                   chk("gnt_order", 128'(gnt), 128'(gnt_q.pop_front()));
            end
            if (rsp_valid != 2'b00) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", 128'(rsp_valid), 128'(0));
                else begin
                    e = rsp_q.pop_front();
                    chk("rsp_valid", 128'(rsp_valid), 128'(e.who));
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", 128'(rsp_err), 128'(e.err));
                    chk("rsp_latency", 128'(cyc - gnt_cyc), 128'(e.lat));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_gnt(input int w);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (gnt[w]) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL gnt_timeout req%0d got=none exp=grant", w);
        end
        @(posedge clk); #1;
    endtask

    task automatic expect_job(input int w, input logic [127:0] e, input int lat, input logic err);
        rsp_t r;
        r.who = (w == 1) ? 2'b10 : 2'b01;
        r.data = e; r.err = err; r.lat = lat;
        gnt_q.push_back(r.who);
        rsp_q.push_back(r);
    endtask

    task automatic issue(input int w, input logic [127:0] d, input logic [127:0] e,
                         input int lat, input logic err);
        expect_job(w, e, lat, err);
        if (w == 1) begin data1 = d; req1 = 1'b1; end
        else        begin data0 = d; req0 = 1'b1; end
        wait_gnt(w);
        if (w == 1) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && rsp_q.size() != 0; i++) @(posedge clk);
        if (rsp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL rsp_timeout got=%0d_pending exp=0", rsp_q.size());
            rsp_q.delete();
        end
        tick(); tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req0  = 1'b1;
        data0 = pk_in(0, 1, 2, 3);
        expect_job(0, pk_out(0, 1, 2, 3), 9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnt", 128'(gnt), 128'(0));
            chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
            chk("rst_rsp_err", 128'(rsp_err), 128'(0));
            chk("rst_busy", 128'(busy), 128'(0));
            chk("rst_mc_start", 128'(mc_start), 128'(0));
            chk("rst_mc_state", mc_state, 128'(0));
            chk("rst_rsp_data", rsp_data, 128'(0));
        end
        @(posedge clk); #1;
        reset = 1'b1;
        wait_gnt(0);
        req0 = 1'b0;
        chk("mc_start_after_gnt", 128'(mc_start), 128'(1));
        chk("mc_state_captured", mc_state, pk_in(0, 1, 2, 3));
        tick();
        chk("mc_start_one_cycle", 128'(mc_start), 128'(0));
        drain();

        issue(1, pk_in(5, 4, 3, 2), pk_out(5, 4, 3, 2), 9, 1'b0);
        drain();

        reset = 1'b0; tick(); tick(); reset = 1'b1;
        data0 = pk_in(0, 1, 2, 3);
        data1 = pk_in(4, 5, 0, 1);
        expect_job(0, pk_out(0, 1, 2, 3), 9, 1'b0);
        expect_job(1, pk_out(4, 5, 0, 1), 9, 1'b0);
        expect_job(0, pk_out(2, 3, 4, 5), 9, 1'b0);
        expect_job(1, pk_out(1, 0, 3, 2), 9, 1'b0);
        req0 = 1'b1; req1 = 1'b1;
        wait_gnt(0); data0 = pk_in(2, 3, 4, 5);
        wait_gnt(1); data1 = pk_in(1, 0, 3, 2);
        wait_gnt(0); req0 = 1'b0;
        wait_gnt(1); req1 = 1'b0;
        drain();

        eng_mode = 1;
        issue(0, pk_in(3, 2, 1, 0), pk_out(3, 2, 1, 0), 7, 1'b0);
        drain();
        eng_mode = 0;

        gnt_q.push_back(2'b10);
        data1 = pk_in(1, 1, 4, 4); req1 = 1'b1;
        wait_gnt(1); req1 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("busy_in_wait", 128'(busy), 128'(1));
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_rsp_valid", 128'(rsp_valid), 128'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        issue(0, pk_in(4, 0, 5, 1), pk_out(4, 0, 5, 1), 9, 1'b0);
        drain();

`ifdef AES_MIXARB_TIMEOUT_EN
        eng_mode = 2;
        issue(1, pk_in(2, 2, 2, 2), 128'(0), 24, 1'b1);
        drain();
        eng_mode = 0;
        issue(0, pk_in(0, 5, 0, 5), pk_out(0, 5, 0, 5), 9, 1'b0);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
